// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the RV32I decode stage: ALU op codes,
// opcode values, the control bundle layout and immediate extraction.
package rv_decode_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd1,  ALU_SUB  = 4'd2,  ALU_AND  = 4'd3,  ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,  ALU_NOT  = 4'd6,  ALU_SLL  = 4'd7,  ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,  ALU_ROL  = 4'd10, ALU_SLT  = 4'd11, ALU_SLTU = 4'd12
    } alu_ops_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] SRCA_RS1 = 2'b00, SRCA_PC  = 2'b01, SRCA_ZERO = 2'b10;
    localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       MemtoReg;
        logic       RegWrite;
        logic       MemWrite;
        logic       MemRead;
        logic [1:0] MemSize;
        logic       MemUnsigned;
        logic       Branch;
        logic [2:0] BrCond;
        logic       Jump;
        logic       JumpReg;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [3:0] ALUOp;
        logic       Illegal;
    } ctrl_t;

    // Inert bundle: also the value the stage presents out of reset.
    localparam ctrl_t CTRL_NOP = '{MemSize: MEM_WORD, ALUOp: ALU_ADD, default: '0};

    function automatic alu_ops_t alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input imm_fmt_t fmt, input logic [31:0] ins);
        case (fmt)
            IMM_I:   return {{20{ins[31]}}, ins[31:20]};
            IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   return {ins[31:12], 12'd0};
            IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle, register
// indices, sign-extended immediate and register-read flags for hazard checks.
module instr_decoder
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output ctrl_t           o_ctrl,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_imm,
    output logic            o_uses_rs1,
    output logic            o_uses_rs2
);
    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic               w_bad;
    imm_fmt_t           w_fmt;
    ctrl_t              w_ctrl;
    logic               w_u1;
    logic               w_u2;
    logic signed [31:0] w_imm_s;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];

    always_comb begin
        w_ctrl = CTRL_NOP;
        w_fmt  = IMM_NONE;
        w_u1   = 1'b0;
        w_u2   = 1'b0;
        w_bad  = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_ctrl.RegWrite = 1'b1;
                w_ctrl.ALUOp    = alu_from_f3(w_f3);
                w_u1 = 1'b1;
                w_u2 = 1'b1;
                if (w_f7 == F7_ALT && w_f3 == 3'b000)      w_ctrl.ALUOp = ALU_SUB;
                else if (w_f7 == F7_ALT && w_f3 == 3'b101) w_ctrl.ALUOp = ALU_SRA;
                else if (w_f7 != F7_BASE)                  w_bad = 1'b1;
            end
            OPC_OP_IMM: begin
                w_ctrl.RegWrite = 1'b1;
                w_ctrl.ALUSrcB  = SRCB_IMM;
                w_ctrl.ALUOp    = alu_from_f3(w_f3);
                w_fmt = IMM_I;
                w_u1  = 1'b1;
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (w_f3 == 3'b101 && w_f7 == F7_ALT)                        w_ctrl.ALUOp = ALU_SRA;
                else if ((w_f3 == 3'b001 || w_f3 == 3'b101) && w_f7 != F7_BASE) w_bad = 1'b1;
            end
            OPC_LOAD: begin
                w_ctrl.MemRead     = 1'b1;
                w_ctrl.MemtoReg    = 1'b1;
                w_ctrl.RegWrite    = 1'b1;
                w_ctrl.MemSize     = w_f3[1:0];
                w_ctrl.MemUnsigned = w_f3[2];
                w_ctrl.ALUSrcB     = SRCB_IMM;
                w_fmt = IMM_I;
                w_u1  = 1'b1;
                w_bad = !(w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                w_ctrl.MemWrite = 1'b1;
                w_ctrl.MemSize  = w_f3[1:0];
                w_ctrl.ALUSrcB  = SRCB_IMM;
                w_fmt = IMM_S;
                w_u1  = 1'b1;
                w_u2  = 1'b1;
                w_bad = !(w_f3 inside {3'b000, 3'b001, 3'b010});
            end
            OPC_BRANCH: begin
                w_ctrl.Branch = 1'b1;
                w_ctrl.BrCond = w_f3;
                w_ctrl.ALUOp  = ALU_SUB;
                w_fmt = IMM_B;
                w_u1  = 1'b1;
                w_u2  = 1'b1;
                w_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OPC_JAL, OPC_JALR: begin
                w_ctrl.Jump     = 1'b1;
                w_ctrl.JumpReg  = (w_opc == OPC_JALR);
                w_ctrl.RegWrite = 1'b1;
                w_ctrl.ALUSrcA  = SRCA_PC;
                w_ctrl.ALUSrcB  = SRCB_FOUR;
                w_fmt = (w_opc == OPC_JALR) ? IMM_I : IMM_J;
                w_u1  = (w_opc == OPC_JALR);
            end
            OPC_LUI, OPC_AUIPC: begin
                w_ctrl.RegWrite = 1'b1;
                w_ctrl.ALUSrcA  = (w_opc == OPC_LUI) ? SRCA_ZERO : SRCA_PC;
                w_ctrl.ALUSrcB  = SRCB_IMM;
                w_fmt = IMM_U;
            end
            default: w_bad = 1'b1;
        endcase
        // Illegal words still travel down the pipe, but with every side effect off.
        if (w_bad) begin
            w_ctrl         = CTRL_NOP;
            w_ctrl.Illegal = 1'b1;
            w_u1           = 1'b0;
            w_u2           = 1'b0;
        end
    end

    assign w_imm_s    = signed'(gen_imm(w_fmt, i_instr));
    assign o_imm      = XLEN'(w_imm_s);
    assign o_ctrl     = w_ctrl;
    assign o_rs1      = i_instr[19:15];
    assign o_rs2      = i_instr[24:20];
    assign o_rd       = i_instr[11:7];
    assign o_uses_rs1 = w_u1;
    assign o_uses_rs2 = w_u2;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// two-entry skid buffer, load-use stall insertion and synchronous flush.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output ctrl_t           out_ctrl
);
    localparam int BW = 2 * XLEN + 15 + $bits(ctrl_t);
    localparam logic [1:0] ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2;
    localparam logic [BW-1:0] BUNDLE_RST = {RESET_PC_TAG, 15'd0, {XLEN{1'b0}}, CTRL_NOP};

    ctrl_t           w_ctrl;
    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_imm;
    logic            w_uses_rs1, w_uses_rs2;
    logic            w_hazard, w_accept;
    logic [BW-1:0]   w_bundle;
    logic [1:0]      w_state_nxt;
    logic            w_load_main, w_load_skid, w_skid_to_main;

    logic [1:0]      r_state;
    logic [BW-1:0]   r_main;
    logic [BW-1:0]   r_skid;

    instr_decoder #(.XLEN(XLEN)) u_dec (
        .i_instr    (in_instr),
        .o_ctrl     (w_ctrl),
        .o_rs1      (w_rs1),
        .o_rs2      (w_rs2),
        .o_rd       (w_rd),
        .o_imm      (w_imm),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2)
    );

    assign w_hazard = in_valid & ex_memread & (ex_rd != 5'd0) &
                      ((w_uses_rs1 & (w_rs1 == ex_rd)) | (w_uses_rs2 & (w_rs2 == ex_rd)));
    assign in_ready = (r_state != ST_TWO) & ~w_hazard & ~flush;
    assign w_accept = in_valid & in_ready;
    assign w_bundle = {in_pc, w_rs1, w_rs2, w_rd, w_imm, w_ctrl};

    always_comb begin
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_load_main = 1'b1;
                end
                ST_ONE: begin
                    if (w_accept && out_ready) begin
                        w_load_main = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_load_skid = 1'b1;
                    end else if (out_ready) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: if (out_ready) begin
                    w_state_nxt    = ST_ONE;
                    w_skid_to_main = 1'b1;
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_main  <= BUNDLE_RST;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main)         r_main <= w_bundle;
            else if (w_skid_to_main) r_main <= r_skid;
            if (w_load_skid)         r_skid <= w_bundle;
        end
    end

    assign out_valid = (r_state != ST_EMPTY);
    assign {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_ctrl} = r_main;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode of representative instructions,
// load-use stall, skid-buffer backpressure, flush and asynchronous reset.
module tb_decode_stage;
    import rv_decode_pkg::*;

    localparam logic [31:0] TAG = 32'hDEAD_BEE0;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, ex_memread, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [4:0]  ex_rd, out_rs1, out_rs2, out_rd;
    ctrl_t       out_ctrl;
    ctrl_t       exp_nop;
    int          n_err = 0;
    int          n_chk = 0;

    decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_rd     (out_rd),
        .out_imm    (out_imm),
        .out_ctrl   (out_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        ex_memread = 1'b0; ex_rd = '0; out_ready = 1'b0;
        exp_nop = '0;
        exp_nop.ALUOp   = 4'd1;
        exp_nop.MemSize = 2'b10;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_pc", out_pc, TAG);
        chk("rst_rd", 32'(out_rd), 0);
        chk("rst_imm", out_imm, 0);
        chk("rst_ctrl", 32'(out_ctrl), 32'(exp_nop));
        reset = 1'b0;

        // add x3,x1,x2
        offer(32'h002081B3, 32'h100);
        out_ready = 1'b1;
        #1 chk("add_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_pc", out_pc, 32'h100);
        chk("add_rd", 32'(out_rd), 3);
        chk("add_rs1", 32'(out_rs1), 1);
        chk("add_rs2", 32'(out_rs2), 2);
        chk("add_aluop", 32'(out_ctrl.ALUOp), 1);
        chk("add_regwrite", 32'(out_ctrl.RegWrite), 1);
        chk("add_srcb", 32'(out_ctrl.ALUSrcB), 0);

        // lw x5,8(x1)
        offer(32'h0080A283, 32'h104);
        @(negedge clk);
        chk("lw_memread", 32'(out_ctrl.MemRead), 1);
        chk("lw_memtoreg", 32'(out_ctrl.MemtoReg), 1);
        chk("lw_memsize", 32'(out_ctrl.MemSize), 2);
        chk("lw_imm", out_imm, 8);
        chk("lw_rd", 32'(out_rd), 5);

        // add x6,x5,x7 behind the load: one bubble
        offer(32'h00728333, 32'h108);
        ex_memread = 1'b1; ex_rd = 5'd5;
        #1 chk("hz_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        chk("hz_bubble", 32'(out_valid), 0);
        ex_memread = 1'b0;
        #1 chk("hz_release", 32'(in_ready), 1);
        @(negedge clk);
        chk("hz_valid", 32'(out_valid), 1);
        chk("hz_pc", out_pc, 32'h108);
        chk("hz_rd", 32'(out_rd), 6);
        chk("hz_rs1", 32'(out_rs1), 5);
        chk("hz_rs2", 32'(out_rs2), 7);
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 0);

        // Stream of 4 with out_ready low for 2 cycles
        offer(32'h123450B7, 32'h200);
        out_ready = 1'b0;
        @(negedge clk);
        chk("s0_pc", out_pc, 32'h200);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_srca", 32'(out_ctrl.ALUSrcA), 2);
        chk("lui_srcb", 32'(out_ctrl.ALUSrcB), 1);
        offer(32'hFFFFFFFF, 32'h204);
        #1 chk("s1_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("s1_hold_pc", out_pc, 32'h200);
        chk("s1_full", 32'(in_ready), 0);
        offer(32'h010000EF, 32'h208);
        out_ready = 1'b1;
        #1 chk("s1_no_ready_path", 32'(in_ready), 0);
        @(negedge clk);
        chk("s2_pc", out_pc, 32'h204);
        chk("ill_flag", 32'(out_ctrl.Illegal), 1);
        chk("ill_regwrite", 32'(out_ctrl.RegWrite), 0);
        chk("ill_memwrite", 32'(out_ctrl.MemWrite), 0);
        chk("ill_branch", 32'(out_ctrl.Branch), 0);
        chk("ill_jump", 32'(out_ctrl.Jump), 0);
        chk("s2_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("s3_pc", out_pc, 32'h208);
        chk("jal_jump", 32'(out_ctrl.Jump), 1);
        chk("jal_jumpreg", 32'(out_ctrl.JumpReg), 0);
        chk("jal_srca", 32'(out_ctrl.ALUSrcA), 1);
        chk("jal_srcb", 32'(out_ctrl.ALUSrcB), 2);
        chk("jal_imm", out_imm, 16);
        offer(32'hFE20AE23, 32'h20C);
        @(negedge clk);
        chk("s4_pc", out_pc, 32'h20C);
        chk("sw_imm", out_imm, 32'hFFFFFFFC);
        chk("sw_memwrite", 32'(out_ctrl.MemWrite), 1);
        chk("sw_regwrite", 32'(out_ctrl.RegWrite), 0);
        chk("sw_rs2", 32'(out_rs2), 2);

        // srai valid and with bad funct7
        offer(32'h40315093, 32'h210);
        @(negedge clk);
        chk("srai_aluop", 32'(out_ctrl.ALUOp), 9);
        chk("srai_legal", 32'(out_ctrl.Illegal), 0);
        offer(32'h02315093, 32'h214);
        @(negedge clk);
        chk("srai_bad_ill", 32'(out_ctrl.Illegal), 1);
        chk("srai_bad_aluop", 32'(out_ctrl.ALUOp), 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("s_end_valid", 32'(out_valid), 0);

        // Fill to TWO, then flush with in_valid held
        offer(32'h002081B3, 32'h300);
        out_ready = 1'b0;
        @(negedge clk);
        offer(32'h002081B3, 32'h304);
        @(negedge clk);
        chk("fl_two", 32'(in_ready), 0);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_valid", 32'(out_valid), 0);
        flush = 1'b0;
        offer(32'h002081B3, 32'h308);
        #1 chk("fl_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("fl_next_pc", out_pc, 32'h308);
        chk("fl_next_valid", 32'(out_valid), 1);

        // Asynchronous reset mid-stream
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_pc", out_pc, TAG);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_after", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I decode stage with a valid/ready handshake and a two-entry skid buffer. It sits between fetch and execute. Each cycle it turns an instruction word plus PC into a control bundle, register indices and a sign-extended immediate. It extends the combinational controller with half-word and unsigned memory access, branch conditions, jumps, illegal-instruction flagging, load-use stall insertion and pipeline flush.

## Interface
Parameters:
- XLEN, 32, datapath/PC/immediate width (≥32)
- RESET_PC_TAG, 0, value driven on out_pc while out_valid=0 after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous; discards all held instructions
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- ex_memread  in  1  instruction currently in execute is a load
- ex_rd  in  5  destination of that load
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  XLEN
- out_rs1, out_rs2, out_rd  out  5 each
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J by format)
- out_ctrl  out  ctrl_t  MemtoReg, RegWrite, MemWrite, MemRead, MemSize[1:0] (00 byte, 01 half, 10 word), MemUnsigned, Branch, BrCond[2:0] (=funct3), Jump, JumpReg, ALUSrcA[1:0] (00 rs1, 01 pc, 10 zero), ALUSrcB[1:0] (00 rs2, 01 imm, 10 const 4), ALUOp[3:0], Illegal

## Operation
- Decode is pure combinational on in_instr. Results are captured into the main register on accept = in_valid & in_ready.
- ALUOp encoding: ADD 1, SUB 2, AND 3, OR 4, XOR 5, NOT 6, SLL 7, SRL 8, SRA 9, ROL 10, SLT 11, SLTU 12.
- R/I-type: full RV32I ALU set, including SLT/SLTU. SUB and SRA are selected by funct7=0100000. SLLI/SRLI/SRAI with a bad funct7 set Illegal.
- LOAD (funct3 000/001/010/100/101): MemSize/MemUnsigned from funct3, ALU ADD, A=rs1, B=imm. STORE (000/001/010) likewise with RegWrite=0. Any other funct3 sets Illegal.
- BRANCH: Branch=1, ALU SUB, BrCond=funct3. funct3 010/011 sets Illegal.
- JAL: Jump=1, A=pc, B=4, RegWrite=1. JALR: additionally JumpReg=1.
- LUI: A=zero, B=imm. AUIPC: A=pc, B=imm.
- Unknown opcode, or any Illegal case: Illegal=1. All write/read/branch/jump enables are 0 and ALUOp=ADD. The bundle is still delivered.
- rs1/rs2 hazard use: rs1 for R, I, LOAD, STORE, BRANCH, JALR; rs2 for R, STORE, BRANCH.
- hazard = in_valid & ex_memread & ex_rd≠0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- in_ready = ~skid_full & ~hazard & ~flush.
- Buffer states: EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept & ~out_ready.
  - ONE→EMPTY on out_ready & ~accept.
  - TWO→ONE on out_ready; skid moves to main. No accept occurs in TWO, since in_ready=0.
- Stall insertion: while hazard holds, nothing is accepted. If main drains, out_valid=0, which is a bubble.
- flush: next state EMPTY and out_valid=0, regardless of out_ready or in_valid. It takes priority over accept.

## Timing
- Latency: accept at edge N gives out_valid=1 with that bundle after edge N. Throughput is 1/cycle when out_ready=1.
- in_ready depends on registered skid_full and on the combinational hazard/flush inputs. There is no path from out_ready to in_ready.
- out_* are stable while out_valid=1 & out_ready=0.
- Reset: out_valid=0, in_ready=1 (absent hazard/flush), buffers EMPTY, out_pc=RESET_PC_TAG. out_rs*/rd/imm=0. out_ctrl all 0 except ALUOp=ADD and MemSize=10.
- Reset asserted mid-transfer: held instructions are lost. Fetch must replay.
- Simultaneous out_ready and accept in ONE: stay ONE, main replaced by the new bundle.

## Structure
- Package `rv_decode_pkg`: alu_ops_t, opcode localparams, mem_size_t, ctrl_t packed struct, immediate-format enum.
- Sub-module `instr_decoder`: combinational instr→{ctrl_t, rs1, rs2, rd, imm, uses_rs1, uses_rs2}. decode_stage holds the hazard logic, skid buffer and state.

## Test plan
- add x3,x1,x2 (0x002081B3), out_ready=1 → next cycle out_valid=1, rd=3, rs1=1, rs2=2, ALUOp=1, RegWrite=1, ALUSrcB=00.
- lw x5,8(x1) (0x0080A283) → MemRead=1, MemtoReg=1, MemSize=10, imm=8. Then ex_memread=1, ex_rd=5 with add x6,x5,x7 (0x00728333) offered → in_ready=0 for that cycle, one bubble, accepted after ex_memread drops.
- Back-to-back stream of 4 instructions with out_ready=0 for 2 cycles → in_ready falls after the second is held. No loss or duplication; order preserved.
- lui x1,0x12345 (0x123450B7) → imm=0x12345000, ALUSrcA=10, ALUSrcB=01.
- 0xFFFFFFFF → Illegal=1, RegWrite=MemWrite=Branch=Jump=0.
- flush while in TWO with in_valid=1 → next cycle out_valid=0, state EMPTY. Async reset mid-stream → out_valid=0 immediately.
